// File: rtl/sap_controller.sv
// SAP-1 control sequencer: six-step ring counter (T1-T6) plus opcode decode
// producing the datapath control word, with a carry/zero flag register for JC/JZ.
module sap_controller (
    input  logic       CLK,
    input  logic       CLR_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       C,
    input  logic       Z,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_load,
    output logic       halt,
    output logic       cf,
    output logic       zf,
    output logic [5:0] t_state
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JC  = 4'b0100;
    localparam logic [3:0] OP_JZ  = 4'b0101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6
    } state_e;

    state_e state_r;
    state_e next_state_s;
    logic   cf_r;
    logic   zf_r;
    logic   en_s;
    logic   alu_op_s;

    assign en_s     = run & CLR_n;
    assign alu_op_s = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign cf       = cf_r;
    assign zf       = zf_r;

    // State register: only enabled edges advance the ring
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_r <= S_T1;
        end else if (run) begin
            state_r <= next_state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Flag register: captures ALU status only at the end of ADD/SUB T6
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            cf_r <= 1'b0;
            zf_r <= 1'b0;
        end else if (run && (state_r == S_T6) && alu_op_s) begin
            cf_r <= C;
            zf_r <= Z;
        end else begin
            cf_r <= cf_r;
            zf_r <= zf_r;
        end
    end

    // Next-state logic: ring T1..T6, HLT diverts from T4 into absorbing HALT
    always_comb begin
        next_state_s = S_T1;
        case (state_r)
            S_T1:    next_state_s = S_T2;
            S_T2:    next_state_s = S_T3;
            S_T3:    next_state_s = S_T4;
            S_T4:    next_state_s = (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    next_state_s = S_T6;
            S_T6:    next_state_s = S_T1;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_T1;
        endcase
    end

    // State indicators: one-hot T-state, cleared while halted
    always_comb begin
        t_state = 6'b000000;
        halt    = 1'b0;
        case (state_r)
            S_T1:    t_state = 6'b000001;
            S_T2:    t_state = 6'b000010;
            S_T3:    t_state = 6'b000100;
            S_T4:    t_state = 6'b001000;
            S_T5:    t_state = 6'b010000;
            S_T6:    t_state = 6'b100000;
            S_HALT:  halt    = 1'b1;
            default: t_state = 6'b000000;
        endcase
    end

    // Control word decode; each case arm enables at most one bus driver
    always_comb begin
        pc_inc   = 1'b0;
        pc_out   = 1'b0;
        pc_load  = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_sub  = 1'b0;
        alu_out  = 1'b0;
        out_load = 1'b0;
        if (en_s) begin
            case (state_r)
                S_T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                S_T2: pc_inc = 1'b1;
                S_T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                S_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_out   = 1'b1;
                            mar_load = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_JC: begin
                            ir_out  = 1'b1;
                            pc_load = cf_r;
                        end
                        OP_JZ: begin
                            ir_out  = 1'b1;
                            pc_load = zf_r;
                        end
                        OP_OUT: begin
                            a_out    = 1'b1;
                            out_load = 1'b1;
                        end
                        default: pc_load = 1'b0;
                    endcase
                end
                S_T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_load  = 1'b1;
                        end
                        default: ram_out = 1'b0;
                    endcase
                end
                S_T6: begin
                    if (alu_op_s) begin
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end else begin
                        alu_out = 1'b0;
                    end
                end
                default: pc_out = 1'b0;
            endcase
        end else begin
            pc_out = 1'b0;
        end
    end

endmodule

// File: doc/sap_controller.md
# sap_controller

Control sequencer for the SAP-1 datapath: a six-step ring counter (T1–T6) plus opcode decode that drives the control word for the PC, MAR, RAM, IR, A/B registers, the adder/subtracter ALU and the output register. It latches the ALU carry/zero outputs into a flag register and uses them for conditional jumps. Sits between the instruction register's opcode nibble and every load/enable line on the shared 8-bit DATA bus.

## Interface
- No parameters; opcode width fixed at 4, T-states fixed at 6.
- CLK  input  1  system clock; all state changes on rising edge.
- CLR_n  input  1  asynchronous, active-low reset.
- run  input  1  step enable; 0 freezes the sequencer and zeros the control word.
- opcode  input  4  IR upper nibble; sampled in T4–T6 only.
- C  input  1  ALU carry/borrow output (combinational).
- Z  input  1  ALU zero output (combinational).
- pc_inc, pc_out, pc_load  output  1 each  program counter increment / drive bus / load from bus.
- mar_load  output  1  MAR load from bus.
- ram_out  output  1  RAM drives bus.
- ir_load, ir_out  output  1 each  IR load / IR operand nibble drives bus.
- a_load, a_out  output  1 each  A register load / drive bus.
- b_load  output  1  B register load.
- alu_sub  output  1  ALU subtract select (maps to ALU `sub`).
- alu_out  output  1  ALU drives bus (maps to ALU `enable`).
- out_load  output  1  output register load.
- halt  output  1  processor halted.
- cf, zf  output  1 each  latched carry and zero flags.
- t_state  output  6  one-hot current T-state (bit0 = T1); all zero in HALT.

## Operation
- States: T1..T6 ring, plus HALT. Reset → T1, cf=zf=0.
- Advance only on rising CLK with run=1: T1→T2→…→T6→T1. run=0: hold state, flags, all control outputs 0 (halt still reflects HALT).
- Control word is a combinational decode of (state, opcode), gated by run and CLR_n; all unlisted outputs 0.
- Fetch, all opcodes: T1 pc_out, mar_load. T2 pc_inc. T3 ram_out, ir_load.
- Execute (T4 / T5 / T6):
  - LDA 0000: ir_out, mar_load / ram_out, a_load / none.
  - ADD 0001: ir_out, mar_load / ram_out, b_load / alu_out, a_load, flags load.
  - SUB 0010: as ADD, with alu_sub=1 in T6.
  - JMP 0011: ir_out, pc_load / none / none.
  - JC 0100: ir_out, pc_load only if cf=1 / none / none.
  - JZ 0101: ir_out, pc_load only if zf=1 / none / none.
  - OUT 1110: a_out, out_load / none / none.
  - HLT 1111: T4 decodes nothing; on the T4 edge (run=1) go to HALT.
  - 0110–1101: NOP, full six cycles.
- Flags load: on the rising edge ending an ADD/SUB T6 with run=1, cf←C, zf←Z. Otherwise unchanged.
- HALT: absorbing; halt=1, all other control outputs 0, t_state=0. Exit only via CLR_n.
- Bus rule: at most one of pc_out, ram_out, ir_out, a_out, alu_out is high in any cycle.

## Timing
- One T-state per enabled clock; every instruction takes exactly 6 enabled cycles, except HLT (4 cycles, then HALT).
- Datapath registers load on the same rising edge that ends the T-state asserting their load.
- Reset values, CLR_n low: all control outputs 0, halt=0, cf=zf=0, t_state=000001.
- CLR_n low mid-instruction: immediate return to T1 with flags cleared. The first enabled edge after deassertion completes T1.
- run toggling mid-instruction: resumes at the held T-state with no step skipped or repeated.
- Flag-dependent jumps use the flags latched before the current instruction. A JC immediately after ADD sees that ADD's carry.

## Test plan
- Reset: hold CLR_n=0 with run=1 → all controls 0, t_state=000001, cf=zf=0. Release, 3 edges → observe T1 (pc_out, mar_load), T2 (pc_inc), T3 (ram_out, ir_load).
- ADD with carry: opcode=0001, C=1, Z=0 through T6 → T6 asserts alu_out, a_load. After the edge cf=1, zf=0. Then SUB with C=0, Z=1 → alu_sub=1 in T6, cf=0, zf=1.
- Conditional jumps: cf=1 with JC → pc_load in T4. cf=0 with JC → no pc_load. zf=1 with JZ → pc_load in T4.
- HLT: opcode=1111 → after T4 edge halt=1, t_state=0, all controls 0 for 20 further cycles. CLR_n pulse → T1, halt=0.
- run gating: deassert run during LDA T5 for 5 cycles → controls 0, state held. Reassert → ram_out, a_load, then T6, then T1.
- Bus exclusivity: all 16 opcodes with random C/Z, 200 instructions → never more than one bus driver high. Undefined opcodes produce only fetch signals.
